// File: rtl/ser_pkg.sv
// ser_pkg: shared definitions for the serial transmitter and its matching
// SIPO receiver.
//   ser_state_t   frame FSM states
//   SER_*_LVL     line levels for idle, start bit and stop bit
//   ser_cw()      counter width helper, never narrower than 1 bit
package ser_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } ser_state_t;

    localparam logic SER_IDLE_LVL  = 1'b1;
    localparam logic SER_START_LVL = 1'b0;
    localparam logic SER_STOP_LVL  = 1'b1;

    // Width needed to count 0..n-1; a count of 1 still needs a 1-bit register.
    function automatic int unsigned ser_cw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ser_bit_timer.sv
// ser_bit_timer: bit-period timer for the serial transmitter.
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset
//   run   in   count while high; the count clears while low
//   tick  out  high in the last clock of each CLKS_PER_BIT-long bit period
module ser_bit_timer
    import ser_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int unsigned TW = ser_cw(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

endmodule

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: parallel-in/serial-out frame transmitter.
// Frame: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Each bit is held for CLKS_PER_BIT clocks.
// Build option: define SER_TX_PARITY_EN to insert the even-parity bit.
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset
//   in_valid  in   source has a word on in_data
//   in_data   in   word to send, sampled only on the accept edge
//   in_ready  out  block can accept a word this cycle
//   ser_out   out  registered serial line, idles high
//   busy      out  frame in progress
//   done      out  one-cycle pulse in the final cycle of the stop bit
module piso_serial_tx
    import ser_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ser_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BW = ser_cw(DATA_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    ser_state_t        state;
    logic [DATA_W-1:0] shift_reg;
    logic [BW-1:0]     bit_cnt;
    logic              tick;
    logic              accept;
`ifdef SER_TX_PARITY_EN
    logic              parity_reg;
`endif

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    // Gated by rst so a frame abandoned in its last stop cycle never reports done.
    assign done     = (state == STOP) && tick && !rst;

    ser_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .run (busy),
        .tick(tick)
    );

    // ser_out is loaded one clock ahead of each bit period, so every bit
    // appears on the line exactly at the boundary the timer marks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ser_out    <= SER_IDLE_LVL;
            shift_reg  <= '0;
            bit_cnt    <= '0;
`ifdef SER_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg  <= in_data;
`ifdef SER_TX_PARITY_EN
                        parity_reg <= ^in_data;
`endif
                        state      <= START;
                        ser_out    <= SER_START_LVL;
                    end
                end
                START: begin
                    if (tick) begin
                        state     <= DATA;
                        ser_out   <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef SER_TX_PARITY_EN
                            state   <= PARITY;
                            ser_out <= parity_reg;
`else
                            state   <= STOP;
                            ser_out <= SER_STOP_LVL;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + BW'(1);
                            ser_out   <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
`ifdef SER_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state   <= STOP;
                        ser_out <= SER_STOP_LVL;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state   <= IDLE;
                        ser_out <= SER_IDLE_LVL;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ser_out <= SER_IDLE_LVL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
module tb_piso_serial_tx;

`ifdef SER_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int DW0 = 8;
    localparam int CPB0 = 4;
    localparam int DW1 = 1;
    localparam int CPB1 = 1;
    localparam int FL0 = (DW0 + 2 + PAR) * CPB0;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, ser_out, busy, done;
    logic [7:0] in_data;
    logic in_valid2, in_ready2, ser_out2, busy2, done2;
    logic [0:0] in_data2;

    always #5 clk = ~clk;

    piso_serial_tx #(.DATA_W(DW0), .CLKS_PER_BIT(CPB0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ser_out(ser_out), .busy(busy), .done(done));

    piso_serial_tx #(.DATA_W(DW1), .CLKS_PER_BIT(CPB1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .ser_out(ser_out2), .busy(busy2), .done(done2));

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;
    logic en2 = 1'b0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // ---------------- behavioural model: a frame is a list of bit levels ----
    logic       m_act [2];
    int         m_pos [2];
    logic [7:0] m_word[2];

    function automatic int flen(input int d);
        return (d == 0) ? (DW0 + 2 + PAR) * CPB0 : (DW1 + 2 + PAR) * CPB1;
    endfunction

    // Level of the line in cycle p (1-based) after accepting word w.
    function automatic logic exp_ser(input logic [7:0] w, input int dw, input int cpb, input int p);
        int idx;
        idx = (p - 1) / cpb;
        if (idx == 0) return 1'b0;
        if (idx <= dw) return w[idx-1];
        if (PAR == 1 && idx == dw + 1) return ^w;
        return 1'b1;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0;
            m_pos[d] = 0;
            m_word[d] = '0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic v;
            logic [7:0] w;
            v = (d == 0) ? in_valid : in_valid2;
            w = (d == 0) ? in_data : {7'b0, in_data2};
            if (rst) begin
                m_act[d] <= 1'b0;
            end else if (!m_act[d]) begin
                if (v) begin
                    m_act[d]  <= 1'b1;
                    m_pos[d]  <= 1;
                    m_word[d] <= w;
                end
            end else if (m_pos[d] == flen(d)) begin
                m_act[d] <= 1'b0;
            end else begin
                m_pos[d] <= m_pos[d] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                logic es, eb, er, ed, as, ab, ar, ad;
                if (m_act[d]) begin
                    es = exp_ser(m_word[d], (d == 0) ? DW0 : DW1, (d == 0) ? CPB0 : CPB1, m_pos[d]);
                    eb = 1'b1;
                    er = 1'b0;
                    ed = (m_pos[d] == flen(d)) && !rst;
                end else begin
                    es = 1'b1;
                    eb = 1'b0;
                    er = !rst;
                    ed = 1'b0;
                end
                as = (d == 0) ? ser_out : ser_out2;
                ab = (d == 0) ? busy : busy2;
                ar = (d == 0) ? in_ready : in_ready2;
                ad = (d == 0) ? done : done2;
                chk((d == 0) ? "d0_ser" : "d1_ser", 32'(as), 32'(es));
                chk((d == 0) ? "d0_busy" : "d1_busy", 32'(ab), 32'(eb));
                chk((d == 0) ? "d0_ready" : "d1_ready", 32'(ar), 32'(er));
                chk((d == 0) ? "d0_done" : "d1_done", 32'(ad), 32'(ed));
            end
        end
    end

    // Random driver for the 1-bit / 1-clock instance.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (en2) begin
                in_valid2 = 1'($urandom_range(0, 1));
                in_data2  = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- directed + random stimulus on dut0 --------------------
    logic cap_ser [1:64];
    logic cap_done[1:64];
    logic cap_rdy [1:64];

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Accept w, then record cycles 1..ncyc after the accept edge.
    task automatic send_cap(input logic [7:0] w, input int ncyc);
        wait_ready();
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            cap_ser[k]  = ser_out;
            cap_done[k] = done;
            cap_rdy[k]  = in_ready;
            in_data     = 8'($urandom);
        end
    endtask

    task automatic check_frame(input string nm, input logic [7:0] w, input logic [10:0] lit);
        send_cap(w, FL0 + 1);
        for (int b = 0; b < DW0 + 2 + PAR; b++)
            chk($sformatf("%s_bit%0d", nm, b), 32'(cap_ser[b*CPB0+2]), 32'(lit[b]));
        chk({nm, "_done_last"}, 32'(cap_done[FL0]), 32'd1);
        chk({nm, "_done_early"}, 32'(cap_done[FL0-1]), 32'd0);
        chk({nm, "_rdy_last"}, 32'(cap_rdy[FL0]), 32'd0);
        chk({nm, "_rdy_after"}, 32'(cap_rdy[FL0+1]), 32'd1);
    endtask

    logic [10:0] lit_a5, lit_07;

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h5A;
        in_valid2 = 1'b1;
        in_data2 = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        // Test 1: reset held with in_valid high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ser", 32'(ser_out), 32'd1);
            chk("rst_ready", 32'(in_ready), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Test 6: one data bit, one clock per bit
        in_valid2 = 1'b1;
        in_data2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        for (int k = 1; k <= 3 + PAR; k++) begin
            @(negedge clk);
            chk($sformatf("t6_ser%0d", k), 32'(ser_out2), 32'd1 - 32'(k == 1));
            chk($sformatf("t6_done%0d", k), 32'(done2), 32'(k == 3 + PAR));
        end
        repeat (2) @(posedge clk);
        #1;

        // Tests 2/3: 0xA5 and 0x07, bit-by-bit
`ifdef SER_TX_PARITY_EN
        lit_a5 = 11'b100_1010_0101 << 1;
        lit_a5[10] = 1'b1;
        lit_a5[9] = 1'b0;
        lit_07 = 11'b110_0000_1110;
`else
        lit_a5 = 11'b011_0100_1010;
        lit_07 = 11'b010_0000_1110;
`endif
        check_frame("a5", 8'hA5, lit_a5);
        check_frame("x07", 8'h07, lit_07);

        // Test 4: valid held across two frames, in_data changed mid-frame
        wait_ready();
        in_valid = 1'b1;
        in_data = 8'h3C;
        @(posedge clk);
        #1;
        in_data = 8'hC3;
        for (int k = 1; k <= FL0; k++) @(negedge clk);
        @(negedge clk);
        chk("b2b_gap_busy", 32'(busy), 32'd0);
        chk("b2b_gap_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("b2b_start_busy", 32'(busy), 32'd1);
        chk("b2b_start_ser", 32'(ser_out), 32'd0);
        in_valid = 1'b0;
        repeat (FL0 + 2) @(posedge clk);
        #1;

        // Test 5: reset in cycle 15 of a 0xFF frame, then a clean 0x00 frame
        send_cap(8'hFF, 14);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h00;
        @(negedge clk);
        chk("abort_ser", 32'(ser_out), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("after_abort_d0", 32'(ser_out), 32'd0);
        repeat (FL0) @(posedge clk);
        #1;

        // Random frames, gaps, held valid, noisy in_data and occasional resets
        en2 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            wait_ready();
            in_valid = 1'b1;
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
            begin
                int n;
                int rst_at;
                n = 0;
                rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, FL0)) : -1;
                while (busy && n < 100) begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_data = 8'($urandom);
                    rst = (n == rst_at);
                    @(posedge clk);
                    #1;
                    n++;
                end
                rst = 1'b0;
                if (busy) chk("frame_timeout", 32'(busy), 32'd0);
            end
            in_valid = 1'b0;
        end
        en2 = 1'b0;
        repeat (FL0 + 4) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
